fft_stim_gen: RTL

- Synthesizable, parametrised frame stimulus source for the FFT core.
- Emits complex frames of N samples on a push/stall stream into fft_top's in_push/in_real/in_imag/in_stall port.
- Supports selectable test patterns (impulse, shifted impulse, rectangular window, LFSR random) and multi-frame runs.
- Used for on-chip self-test and as a reusable bench driver.

---
 rtl/fft_stim_gen.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/fft_stim_gen.sv
`default_nettype none
// ============================================================================
// Module   : fft_stim_gen
// Brief    : Frame stimulus source for the FFT core (impulse/rect/LFSR).
//            Optional transfer signature output enabled by FFT_STIM_SIG_EN.
// Revision : 1.0
// ============================================================================
module fft_stim_gen #(
  parameter int                DATA_W     = 16,
  parameter int                N          = 16,
  parameter logic [DATA_W-1:0] AMP        = 16'h7fff,
  parameter int                RECT_K     = 5,
  parameter int                GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        num_frames,
  input  logic [31:0]       seed,
  input  logic              abort,
  output logic              out_push,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  input  logic              out_stall,
  output logic              busy,
  output logic              done,
  output logic [7:0]        frame_cnt
`ifdef FFT_STIM_SIG_EN
  ,
  output logic [31:0]       sig
`endif
);

  localparam int                 c_IDX_W    = $clog2(N);
  localparam int                 c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N - 1);
  localparam logic [c_IDX_W-1:0] c_RECT_LO  = c_IDX_W'(RECT_K);
  localparam logic [c_IDX_W-1:0] c_RECT_HI  = c_IDX_W'(N - RECT_K);
  localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [31:0]        c_TAPS     = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = s[0] ? ((s >> 1) ^ c_TAPS) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [c_IDX_W-1:0] i);
    logic hit;
    hit = 1'b0;
    case (m)
      2'd0:    hit = (i == '0);
      2'd1:    hit = (i == c_IDX_W'(1));
      2'd2:    hit = (i <= c_RECT_LO) || (i >= c_RECT_HI);
      default: hit = 1'b0;
    endcase
    pattern = hit ? AMP : '0;
  endfunction

  state_t              r_state, w_state_next;
  logic [c_IDX_W-1:0]  r_idx;
  logic [7:0]          r_frame_cnt;
  logic [7:0]          r_num_frames;
  logic [1:0]          r_mode;
  logic                r_abort;
  logic [31:0]         r_lfsr;
  logic [c_GAP_W-1:0]  r_gap_cnt;
  logic                r_push;
  logic [DATA_W-1:0]   r_real;
  logic [DATA_W-1:0]   r_imag;

  logic                w_xfer;
  logic                w_last;
  logic                w_stop;
  logic                w_start;
  logic                w_load;
  logic                w_clear;
  logic [1:0]          w_gen_mode;
  logic [31:0]         w_gen_base;
  logic [c_IDX_W-1:0]  w_gen_idx;
  logic [31:0]         w_step1;
  logic [31:0]         w_step2;
  logic [DATA_W-1:0]   w_gen_real;
  logic [DATA_W-1:0]   w_gen_imag;

  assign w_xfer = r_push & ~out_stall;
  assign w_last = w_xfer && (r_idx == c_IDX_LAST);
  assign w_stop = ((r_num_frames != 8'd0) && (r_frame_cnt + 8'd1 == r_num_frames)) || r_abort || abort;

  // Next-sample generator; in IDLE it works from the live inputs so sample 0
  // is ready on the cycle right after start.
  assign w_gen_mode = (r_state == ST_IDLE) ? mode : r_mode;
  assign w_gen_base = (r_state != ST_IDLE) ? r_lfsr : ((seed == 32'd0) ? 32'd1 : seed);
  assign w_gen_idx  = (r_state == ST_RUN) ? r_idx + c_IDX_W'(1) : '0;
  assign w_step1    = lfsr_step(w_gen_base);
  assign w_step2    = lfsr_step(w_step1);
  assign w_gen_real = (w_gen_mode == 2'd3) ? w_step1[DATA_W-1:0] : pattern(w_gen_mode, w_gen_idx);
  assign w_gen_imag = (w_gen_mode == 2'd3) ? w_step2[DATA_W-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start      = 1'b1;
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          if (w_stop) begin
            w_clear      = 1'b1;
            w_state_next = ST_DONE;
          end else if (GAP_CYCLES > 0) begin
            w_clear      = 1'b1;
            w_state_next = ST_GAP;
          end else begin
            w_load       = 1'b1;
          end
        end else if (w_xfer) begin
          w_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_load       = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx        <= '0;
      r_frame_cnt  <= 8'd0;
      r_num_frames <= 8'd0;
      r_mode       <= 2'd0;
      r_abort      <= 1'b0;
      r_lfsr       <= 32'd1;
      r_gap_cnt    <= '0;
      r_push       <= 1'b0;
      r_real       <= '0;
      r_imag       <= '0;
    end else begin
      if (w_load) begin
        r_push <= 1'b1;
        r_real <= w_gen_real;
        r_imag <= w_gen_imag;
        r_lfsr <= (w_gen_mode == 2'd3) ? w_step2 : w_gen_base;
      end else if (w_clear) begin
        r_push <= 1'b0;
        r_real <= '0;
        r_imag <= '0;
      end

      if (w_start) begin
        r_mode       <= mode;
        r_num_frames <= num_frames;
        r_frame_cnt  <= 8'd0;
        r_idx        <= '0;
        r_abort      <= abort;
      end else begin
        if (w_xfer) r_idx <= r_idx + c_IDX_W'(1);
        if (w_last) r_frame_cnt <= r_frame_cnt + 8'd1;
        // Abort only takes effect at a frame boundary, so hold it until DONE.
        if (r_state == ST_DONE)                                   r_abort <= 1'b0;
        else if (abort && (r_state == ST_RUN || r_state == ST_GAP)) r_abort <= 1'b1;
      end

      if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
      else                   r_gap_cnt <= '0;
    end
  end

  assign out_push  = r_push;
  assign out_real  = r_real;
  assign out_imag  = r_imag;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_GAP);
  assign done      = (r_state == ST_DONE);
  assign frame_cnt = r_frame_cnt;

`ifdef FFT_STIM_SIG_EN
  logic [31:0]         r_sig;
  logic [2*DATA_W-1:0] w_sig_pair;
  logic [31:0]         w_sig_data;

  assign w_sig_pair = {r_real, r_imag};

  generate
    if (2 * DATA_W >= 32) begin : g_sig_trunc
      assign w_sig_data = w_sig_pair[31:0];
    end else begin : g_sig_ext
      assign w_sig_data = {{(32 - 2 * DATA_W){1'b0}}, w_sig_pair};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    r_sig <= 32'd0;
    else if (w_start) r_sig <= 32'd0;
    else if (w_xfer)  r_sig <= {r_sig[30:0], r_sig[31]} ^ w_sig_data;
  end

  assign sig = r_sig;
`endif

endmodule
`default_nettype wire
